execute_stage: RTL and testbench

- Execute stage of the 5-stage 16-bit pipeline. Sole reader of the ID/EX register bank that decode writes.
- Forwards operands, runs the ALU, and resolves branches and jumps.
- Registers results into the EX/MEM bank. Drives takeBranch_EXMEM back to fetch and decode, which squash their own entries when it is set.

---
 rtl/execute_stage_if.sv | 36 +++
 rtl/execute_stage.sv | 165 ++++++++++++++++
 tb/tb_execute_stage.sv | 292 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/execute_stage_if.sv
// ID/EX register bank seen by the execute stage: decode drives it (master), execute reads it (slave).
interface execute_stage_if #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RADDR = 3
);
    logic [WIDTH-1:0] PC2_IDEX;
    logic [WIDTH-1:0] Rd1_IDEX;
    logic [WIDTH-1:0] Rd2_IDEX;
    logic [WIDTH-1:0] Imm_IDEX;
    logic [RADDR-1:0] Rd1Addr_IDEX;
    logic [RADDR-1:0] Rd2Addr_IDEX;
    logic [RADDR-1:0] WrR_IDEX;
    logic [4:0]       ALUOp_IDEX;
    logic [1:0]       ALUF_IDEX;
    logic             ALUSrc_IDEX;
    logic             Branch_IDEX;
    logic             Jump_IDEX;
    logic             MemtoReg_IDEX;
    logic             MemWrite_IDEX;
    logic             MemRead_IDEX;
    logic             RegWrite_IDEX;
    logic             Dump_IDEX;
    logic             halt_IDEX;

    modport master (
        output PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX, Rd1Addr_IDEX, Rd2Addr_IDEX, WrR_IDEX,
               ALUOp_IDEX, ALUF_IDEX, ALUSrc_IDEX, Branch_IDEX, Jump_IDEX, MemtoReg_IDEX,
               MemWrite_IDEX, MemRead_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX
    );

    modport slave (
        input  PC2_IDEX, Rd1_IDEX, Rd2_IDEX, Imm_IDEX, Rd1Addr_IDEX, Rd2Addr_IDEX, WrR_IDEX,
               ALUOp_IDEX, ALUF_IDEX, ALUSrc_IDEX, Branch_IDEX, Jump_IDEX, MemtoReg_IDEX,
               MemWrite_IDEX, MemRead_IDEX, RegWrite_IDEX, Dump_IDEX, halt_IDEX
    );
endinterface

// File: rtl/execute_stage.sv
// Execute stage: operand forwarding, ALU, branch/jump resolution, EX/MEM register bank.
// Macro EXECUTE_FWD_EN enables EX/MEM and MEM/WB operand forwarding; otherwise operands come straight from ID/EX.
module execute_stage #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned RADDR = 3
) (
    input  logic             clk,
    input  logic             rst,
    execute_stage_if.slave   idex,
    input  logic [WIDTH-1:0] writeData,
    input  logic [RADDR-1:0] WrR_MEMWB,
    input  logic             RegWrite_MEMWB,
    output logic [WIDTH-1:0] ALUout_EXMEM,
    output logic [WIDTH-1:0] Rd2_EXMEM,
    output logic [WIDTH-1:0] target_EXMEM,
    output logic [RADDR-1:0] WrR_EXMEM,
    output logic             takeBranch_EXMEM,
    output logic             RegWrite_EXMEM,
    output logic             MemtoReg_EXMEM,
    output logic             MemWrite_EXMEM,
    output logic             MemRead_EXMEM,
    output logic             Dump_EXMEM,
    output logic             halt_EXMEM
);
    localparam int unsigned SHW = $clog2(WIDTH);

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b0;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] alu_res;
    logic [WIDTH-1:0] target_c;
    logic             take_c;

`ifdef EXECUTE_FWD_EN
    // EX/MEM wins over MEM/WB; a load in EX/MEM has no data yet, so it is skipped.
    function automatic logic [WIDTH-1:0] fwd(
        input logic [RADDR-1:0] a, input logic [WIDTH-1:0] d,
        input logic [WIDTH-1:0] ex_data, input logic [RADDR-1:0] ex_wr, input logic ex_rw, input logic ex_m2r,
        input logic [WIDTH-1:0] wb_data, input logic [RADDR-1:0] wb_wr, input logic wb_rw);
        if (ex_rw && (ex_wr == a) && !ex_m2r) return ex_data;
        else if (wb_rw && (wb_wr == a))      return wb_data;
        else                                 return d;
    endfunction

    assign op_a  = fwd(idex.Rd1Addr_IDEX, idex.Rd1_IDEX, ALUout_EXMEM, WrR_EXMEM, RegWrite_EXMEM,
                       MemtoReg_EXMEM, writeData, WrR_MEMWB, RegWrite_MEMWB);
    assign op_b0 = fwd(idex.Rd2Addr_IDEX, idex.Rd2_IDEX, ALUout_EXMEM, WrR_EXMEM, RegWrite_EXMEM,
                       MemtoReg_EXMEM, writeData, WrR_MEMWB, RegWrite_MEMWB);
`else
    logic unused_fwd;
    assign unused_fwd = ^{writeData, WrR_MEMWB, RegWrite_MEMWB, idex.Rd1Addr_IDEX, idex.Rd2Addr_IDEX};
    assign op_a  = idex.Rd1_IDEX;
    assign op_b0 = idex.Rd2_IDEX;
`endif

    assign op_b = idex.ALUSrc_IDEX ? idex.Imm_IDEX : op_b0;

    // Rotate/shift family: 00 rol, 01 sll, 10 ror, 11 srl
    function automatic logic [WIDTH-1:0] shift_op(input logic [1:0] sel, input logic [WIDTH-1:0] x,
                                                  input logic [SHW-1:0] s);
        logic [2*WIDTH-1:0] l;
        logic [2*WIDTH-1:0] r;
        l = {x, x} << s;
        r = {x, x} >> s;
        case (sel)
            2'b00:   return l[2*WIDTH-1:WIDTH];
            2'b01:   return x << s;
            2'b10:   return r[WIDTH-1:0];
            default: return x >> s;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] arith_op(input logic [1:0] sel, input logic [WIDTH-1:0] a,
                                                  input logic [WIDTH-1:0] b);
        case (sel)
            2'b00:   return a + b;
            2'b01:   return b - a;
            2'b10:   return a ^ b;
            default: return a & ~b;
        endcase
    endfunction

    function automatic logic [WIDTH-1:0] bit_rev(input logic [WIDTH-1:0] x);
        logic [WIDTH-1:0] r;
        for (int i = 0; i < int'(WIDTH); i++) r[i] = x[WIDTH-1-i];
        return r;
    endfunction

    // ALU decode on the opcode's upper three bits
    always_comb begin
        logic [WIDTH:0] sum_c;
        logic           set_c;
        alu_res = '0;
        sum_c   = {1'b0, op_a} + {1'b0, op_b};
        set_c   = 1'b0;
        case (idex.ALUOp_IDEX[4:2])
            3'b010: alu_res = arith_op(idex.ALUOp_IDEX[1:0], op_a, op_b);
            3'b100: alu_res = (idex.ALUOp_IDEX[1:0] == 2'b10)
                              ? ((op_a << 8) | {{(WIDTH-8){1'b0}}, op_b[7:0]})
                              : sum_c[WIDTH-1:0];
            3'b101: alu_res = shift_op(idex.ALUOp_IDEX[1:0], op_a, op_b[SHW-1:0]);
            3'b110: begin
                case (idex.ALUOp_IDEX[1:0])
                    2'b00:   alu_res = op_b;
                    2'b01:   alu_res = bit_rev(op_a);
                    2'b10:   alu_res = shift_op(idex.ALUF_IDEX, op_a, op_b[SHW-1:0]);
                    default: alu_res = arith_op(idex.ALUF_IDEX, op_a, op_b);
                endcase
            end
            3'b111: begin
                case (idex.ALUOp_IDEX[1:0])
                    2'b00:   set_c = (op_a == op_b);
                    2'b01:   set_c = ($signed(op_a) < $signed(op_b));
                    2'b10:   set_c = ($signed(op_a) <= $signed(op_b));
                    default: set_c = sum_c[WIDTH];
                endcase
                alu_res = {{(WIDTH-1){1'b0}}, set_c};
            end
            default: alu_res = '0;
        endcase
    end

    // Branch condition on operand A; jumps are unconditional
    always_comb begin
        logic cond_c;
        case (idex.ALUOp_IDEX[1:0])
            2'b00:   cond_c = (op_a == '0);
            2'b01:   cond_c = (op_a != '0);
            2'b10:   cond_c = op_a[WIDTH-1];
            default: cond_c = !op_a[WIDTH-1];
        endcase
        take_c   = idex.Jump_IDEX || (idex.Branch_IDEX && cond_c);
        target_c = (idex.Jump_IDEX && idex.ALUOp_IDEX[0]) ? (op_a + idex.Imm_IDEX)
                                                          : (idex.PC2_IDEX + idex.Imm_IDEX);
    end

    // EX/MEM bank; a taken branch in EX/MEM squashes the wrong-path instruction now in EX
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ALUout_EXMEM     <= '0;
            Rd2_EXMEM        <= '0;
            target_EXMEM     <= '0;
            WrR_EXMEM        <= '0;
            takeBranch_EXMEM <= 1'b0;
            RegWrite_EXMEM   <= 1'b0;
            MemtoReg_EXMEM   <= 1'b0;
            MemWrite_EXMEM   <= 1'b0;
            MemRead_EXMEM    <= 1'b0;
            Dump_EXMEM       <= 1'b0;
            halt_EXMEM       <= 1'b0;
        end else begin
            ALUout_EXMEM     <= idex.Jump_IDEX ? idex.PC2_IDEX : alu_res;
            Rd2_EXMEM        <= op_b0;
            target_EXMEM     <= target_c;
            WrR_EXMEM        <= idex.WrR_IDEX;
            MemtoReg_EXMEM   <= idex.MemtoReg_IDEX;
            takeBranch_EXMEM <= !takeBranch_EXMEM && take_c;
            RegWrite_EXMEM   <= !takeBranch_EXMEM && idex.RegWrite_IDEX;
            MemWrite_EXMEM   <= !takeBranch_EXMEM && idex.MemWrite_IDEX;
            MemRead_EXMEM    <= !takeBranch_EXMEM && idex.MemRead_IDEX;
            Dump_EXMEM       <= !takeBranch_EXMEM && idex.Dump_IDEX;
            halt_EXMEM       <= !takeBranch_EXMEM && idex.halt_IDEX;
        end
    end
endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: directed ID/EX vectors, expected EX/MEM values queued and checked by a monitor.
module tb_execute_stage;
    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] writeData;
    logic [2:0]  WrR_MEMWB;
    logic        RegWrite_MEMWB;
    logic [15:0] ALUout_EXMEM, Rd2_EXMEM, target_EXMEM;
    logic [2:0]  WrR_EXMEM;
    logic        takeBranch_EXMEM, RegWrite_EXMEM, MemtoReg_EXMEM, MemWrite_EXMEM;
    logic        MemRead_EXMEM, Dump_EXMEM, halt_EXMEM;

    execute_stage_if #(.WIDTH(16), .RADDR(3)) idex ();

    execute_stage #(.WIDTH(16), .RADDR(3)) dut (
        .clk(clk), .rst(rst), .idex(idex),
        .writeData(writeData), .WrR_MEMWB(WrR_MEMWB), .RegWrite_MEMWB(RegWrite_MEMWB),
        .ALUout_EXMEM(ALUout_EXMEM), .Rd2_EXMEM(Rd2_EXMEM), .target_EXMEM(target_EXMEM),
        .WrR_EXMEM(WrR_EXMEM), .takeBranch_EXMEM(takeBranch_EXMEM), .RegWrite_EXMEM(RegWrite_EXMEM),
        .MemtoReg_EXMEM(MemtoReg_EXMEM), .MemWrite_EXMEM(MemWrite_EXMEM), .MemRead_EXMEM(MemRead_EXMEM),
        .Dump_EXMEM(Dump_EXMEM), .halt_EXMEM(halt_EXMEM)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] pc2, rd1, rd2, imm, wd;
        logic [2:0]  a1, a2, wr, wr_wb;
        logic [4:0]  op;
        logic [1:0]  f;
        logic        src, br, jmp, m2r, mw, mr, rw, dump, halt, rw_wb;
    } in_t;

    typedef struct {
        string       name;
        logic [15:0] alu, st, tgt;
        logic [2:0]  wr;
        logic        take, rw, m2r, mw, mr, dump, halt;
        bit          chk_data, chk_tgt;
    } exp_t;

    exp_t q[$];
    int   tests_run    = 0;
    int   tests_failed = 0;

    function automatic in_t nop_in();
        in_t v;
        v.pc2 = '0; v.rd1 = '0; v.rd2 = '0; v.imm = '0; v.wd = '0;
        v.a1 = '0; v.a2 = '0; v.wr = '0; v.wr_wb = '0; v.op = '0; v.f = '0;
        v.src = 0; v.br = 0; v.jmp = 0; v.m2r = 0; v.mw = 0; v.mr = 0; v.rw = 0;
        v.dump = 0; v.halt = 0; v.rw_wb = 0;
        return v;
    endfunction

    function automatic exp_t mk_exp(input string name, input logic [15:0] alu, input logic [15:0] st,
                                    input logic [2:0] wr);
        exp_t e;
        e.name = name; e.alu = alu; e.st = st; e.tgt = '0; e.wr = wr;
        e.take = 0; e.rw = 0; e.m2r = 0; e.mw = 0; e.mr = 0; e.dump = 0; e.halt = 0;
        e.chk_data = 1; e.chk_tgt = 0;
        return e;
    endfunction

    task automatic apply(input in_t v);
        idex.PC2_IDEX = v.pc2; idex.Rd1_IDEX = v.rd1; idex.Rd2_IDEX = v.rd2; idex.Imm_IDEX = v.imm;
        idex.Rd1Addr_IDEX = v.a1; idex.Rd2Addr_IDEX = v.a2; idex.WrR_IDEX = v.wr;
        idex.ALUOp_IDEX = v.op; idex.ALUF_IDEX = v.f; idex.ALUSrc_IDEX = v.src;
        idex.Branch_IDEX = v.br; idex.Jump_IDEX = v.jmp; idex.MemtoReg_IDEX = v.m2r;
        idex.MemWrite_IDEX = v.mw; idex.MemRead_IDEX = v.mr; idex.RegWrite_IDEX = v.rw;
        idex.Dump_IDEX = v.dump; idex.halt_IDEX = v.halt;
        writeData = v.wd; WrR_MEMWB = v.wr_wb; RegWrite_MEMWB = v.rw_wb;
    endtask

    task automatic issue(input in_t v, input exp_t e);
        @(negedge clk);
        apply(v);
        q.push_back(e);
    endtask

    function automatic bit field_bad(input string name, input string fld, input logic [15:0] got,
                                     input logic [15:0] want);
        if (got !== want) begin
            $display("FAIL %s %s: got %h expected %h", name, fld, got, want);
            return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic check_zero(input string name);
        tests_run++;
        if ({ALUout_EXMEM, Rd2_EXMEM, target_EXMEM, WrR_EXMEM, takeBranch_EXMEM, RegWrite_EXMEM,
             MemtoReg_EXMEM, MemWrite_EXMEM, MemRead_EXMEM, Dump_EXMEM, halt_EXMEM} !== '0) begin
            $display("FAIL %s: outputs not cleared, alu=%h st=%h tgt=%h take=%b rw=%b mw=%b expected all 0",
                     name, ALUout_EXMEM, Rd2_EXMEM, target_EXMEM, takeBranch_EXMEM, RegWrite_EXMEM,
                     MemWrite_EXMEM);
            tests_failed++;
        end
    endtask

    // Monitor: one EX/MEM capture per cycle, compared against the oldest queued expectation
    initial begin
        exp_t e;
        bit   bad;
        forever begin
            @(posedge clk);
            #1;
            if (rst === 1'b1 && q.size() > 0) begin
                e   = q.pop_front();
                bad = 0;
                tests_run++;
                bad |= field_bad(e.name, "take",  16'(takeBranch_EXMEM), 16'(e.take));
                bad |= field_bad(e.name, "rw",    16'(RegWrite_EXMEM),   16'(e.rw));
                bad |= field_bad(e.name, "mw",    16'(MemWrite_EXMEM),   16'(e.mw));
                bad |= field_bad(e.name, "mr",    16'(MemRead_EXMEM),    16'(e.mr));
                bad |= field_bad(e.name, "dump",  16'(Dump_EXMEM),       16'(e.dump));
                bad |= field_bad(e.name, "halt",  16'(halt_EXMEM),       16'(e.halt));
                if (e.chk_data) begin
                    bad |= field_bad(e.name, "alu", ALUout_EXMEM, e.alu);
                    bad |= field_bad(e.name, "st",  Rd2_EXMEM,    e.st);
                    bad |= field_bad(e.name, "wr",  16'(WrR_EXMEM),      16'(e.wr));
                    bad |= field_bad(e.name, "m2r", 16'(MemtoReg_EXMEM), 16'(e.m2r));
                end
                if (e.chk_tgt) bad |= field_bad(e.name, "tgt", target_EXMEM, e.tgt);
                if (bad) tests_failed++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t  v;
        exp_t e;
        logic [15:0] fa, fb;
        rst = 1'b0;
        apply(nop_in());
        #12;
        check_zero("reset_init");
        @(negedge clk);
        rst = 1'b1;

        v = nop_in(); v.rd1 = 16'h7FFF; v.a1 = 3'd1; v.imm = 16'h0001; v.src = 1; v.op = 5'b01000;
        v.rd2 = 16'h1234; v.a2 = 3'd5; v.rw = 1; v.wr = 3'd2;
        e = mk_exp("addi", 16'h8000, 16'h1234, 3'd2); e.rw = 1; issue(v, e);

        v = nop_in(); v.rd1 = 16'hFFFF; v.a1 = 3'd4; v.imm = 16'h0001; v.src = 1; v.op = 5'b01000;
        v.a2 = 3'd6; v.rw = 1; v.wr = 3'd2;
        e = mk_exp("addi_wrap", 16'h0000, 16'h0000, 3'd2); e.rw = 1; issue(v, e);

        // EX/MEM writes r3=0011 while MEM/WB writes r3=0022: EX/MEM wins
        v = nop_in(); v.imm = 16'h0011; v.src = 1; v.op = 5'b11000; v.wr = 3'd3; v.rw = 1;
        e = mk_exp("lbi_r3", 16'h0011, 16'h0000, 3'd3); e.rw = 1; issue(v, e);

`ifdef EXECUTE_FWD_EN
        fa = 16'h0011;
`else
        fa = 16'h0AAA;
`endif
        v = nop_in(); v.a1 = 3'd3; v.rd1 = 16'h0AAA; v.src = 1; v.op = 5'b01000; v.wr = 3'd4; v.rw = 1;
        v.wd = 16'h0022; v.wr_wb = 3'd3; v.rw_wb = 1;
        e = mk_exp("fwd_prio", fa, 16'h0000, 3'd4); e.rw = 1; issue(v, e);

        // EX/MEM holds a load to r3: MEM/WB value must be used instead
        v = nop_in(); v.imm = 16'h0055; v.src = 1; v.op = 5'b11000; v.wr = 3'd3; v.rw = 1; v.m2r = 1;
        e = mk_exp("load_r3", 16'h0055, 16'h0000, 3'd3); e.rw = 1; e.m2r = 1; issue(v, e);

`ifdef EXECUTE_FWD_EN
        fa = 16'h0022; fb = 16'h0022;
`else
        fa = 16'h0AAA; fb = 16'h0BBB;
`endif
        v = nop_in(); v.a1 = 3'd3; v.rd1 = 16'h0AAA; v.a2 = 3'd3; v.rd2 = 16'h0BBB; v.src = 1;
        v.op = 5'b01000; v.wr = 3'd5; v.rw = 1; v.wd = 16'h0022; v.wr_wb = 3'd3; v.rw_wb = 1;
        e = mk_exp("fwd_m2r", fa, fb, 3'd5); e.rw = 1; issue(v, e);

        v = nop_in(); v.a1 = 3'd1; v.rd1 = 16'h0005; v.pc2 = 16'h0010; v.imm = 16'hFFFC; v.br = 1;
        v.op = 5'b01101;
        e = mk_exp("bnez", 16'h0000, 16'h0000, 3'd0); e.take = 1; e.tgt = 16'h000C; e.chk_tgt = 1;
        issue(v, e);

        // Wrong-path store that is also a would-be-taken branch: everything squashed
        v = nop_in(); v.mw = 1; v.rw = 1; v.mr = 1; v.dump = 1; v.halt = 1; v.br = 1; v.op = 5'b01100;
        e = mk_exp("squash", 16'h0000, 16'h0000, 3'd0); e.chk_data = 0; issue(v, e);

        v = nop_in(); v.a1 = 3'd2; v.rd1 = 16'h0100; v.imm = 16'h0004; v.pc2 = 16'h0042; v.jmp = 1;
        v.op = 5'b00111; v.rw = 1; v.wr = 3'd7;
        e = mk_exp("jalr", 16'h0042, 16'h0000, 3'd7); e.rw = 1; e.take = 1; e.tgt = 16'h0104;
        e.chk_tgt = 1; issue(v, e);

        v = nop_in(); v.rw = 1; v.op = 5'b01000;
        e = mk_exp("squash_jalr", 16'h0000, 16'h0000, 3'd0); e.chk_data = 0; issue(v, e);

        v = nop_in(); v.rd1 = 16'hFFFF; v.pc2 = 16'h0100; v.imm = 16'h0020; v.jmp = 1; v.op = 5'b00100;
        e = mk_exp("jump", 16'h0100, 16'h0000, 3'd0); e.take = 1; e.tgt = 16'h0120; e.chk_tgt = 1;
        issue(v, e);

        v = nop_in();
        e = mk_exp("bubble", 16'h0000, 16'h0000, 3'd0); e.chk_data = 0; issue(v, e);

        v = nop_in(); v.a1 = 3'd1; v.rd1 = 16'h8000; v.imm = 16'h0001; v.src = 1; v.op = 5'b11101;
        v.wr = 3'd1; v.rw = 1;
        e = mk_exp("slt", 16'h0001, 16'h0000, 3'd1); e.rw = 1; issue(v, e);

        v = nop_in(); v.rd1 = 16'h8000; v.rd2 = 16'h8000; v.op = 5'b11111; v.wr = 3'd2; v.rw = 1;
        e = mk_exp("sco", 16'h0001, 16'h8000, 3'd2); e.rw = 1; issue(v, e);

        v = nop_in(); v.rd1 = 16'h0005; v.imm = 16'h0005; v.src = 1; v.op = 5'b11110;
        e = mk_exp("sle_eq", 16'h0001, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h0005; v.imm = 16'h0006; v.src = 1; v.op = 5'b11100;
        e = mk_exp("seq_ne", 16'h0000, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h8001; v.imm = 16'h0001; v.src = 1; v.op = 5'b10100;
        e = mk_exp("rol", 16'h0003, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h0001; v.imm = 16'h0004; v.src = 1; v.op = 5'b10110;
        e = mk_exp("ror", 16'h1000, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h8000; v.imm = 16'h000F; v.src = 1; v.op = 5'b10111;
        e = mk_exp("srl", 16'h0001, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h0003; v.imm = 16'h0002; v.src = 1; v.op = 5'b10101;
        e = mk_exp("sll", 16'h000C, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h0003; v.rd2 = 16'h0010; v.op = 5'b11011; v.f = 2'b01;
        e = mk_exp("r_sub", 16'h000D, 16'h0010, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h00FF; v.rd2 = 16'h0F0F; v.op = 5'b11011; v.f = 2'b10;
        e = mk_exp("r_xor", 16'h0FF0, 16'h0F0F, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h00FF; v.rd2 = 16'h0F0F; v.op = 5'b11011; v.f = 2'b11;
        e = mk_exp("r_andn", 16'h00F0, 16'h0F0F, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h0001; v.rd2 = 16'h0001; v.op = 5'b11010; v.f = 2'b10;
        e = mk_exp("r_ror", 16'h8000, 16'h0001, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h00AB; v.imm = 16'h00CD; v.src = 1; v.op = 5'b10010;
        e = mk_exp("slbi", 16'hABCD, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h0001; v.op = 5'b11001;
        e = mk_exp("btr", 16'h8000, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.rd1 = 16'h0010; v.imm = 16'h0004; v.src = 1; v.rd2 = 16'h5555; v.op = 5'b10000;
        v.mw = 1;
        e = mk_exp("st_addr", 16'h0014, 16'h5555, 3'd0); e.mw = 1; issue(v, e);

        v = nop_in(); v.rd1 = 16'h0001; v.br = 1; v.op = 5'b01110;
        e = mk_exp("bltz_nt", 16'h0000, 16'h0000, 3'd0); issue(v, e);

        v = nop_in(); v.pc2 = 16'h0020; v.imm = 16'h0002; v.br = 1; v.op = 5'b01111;
        e = mk_exp("bgez", 16'h0000, 16'h0000, 3'd0); e.take = 1; e.tgt = 16'h0022; e.chk_tgt = 1;
        issue(v, e);

        // Reset while a taken branch sits in EX/MEM: cleared at once, held through an edge
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_zero("reset_async");
        v = nop_in(); v.mw = 1; v.rw = 1; v.jmp = 1; v.rd1 = 16'h1111; v.op = 5'b01000;
        apply(v);
        @(posedge clk);
        #1;
        check_zero("reset_hold");

        @(negedge clk);
        rst = 1'b1;
        v = nop_in(); v.rd1 = 16'h0003; v.imm = 16'h0001; v.src = 1; v.op = 5'b01001; v.rw = 1; v.wr = 3'd6;
        apply(v);
        e = mk_exp("first_after_rst", 16'hFFFE, 16'h0000, 3'd6); e.rw = 1;
        q.push_back(e);

        v = nop_in(); v.imm = 16'h0030; v.src = 1; v.op = 5'b10001; v.rw = 1; v.wr = 3'd6; v.m2r = 1;
        v.mr = 1; v.dump = 1; v.halt = 1;
        e = mk_exp("ld_dump_halt", 16'h0030, 16'h0000, 3'd6); e.rw = 1; e.m2r = 1; e.mr = 1;
        e.dump = 1; e.halt = 1; issue(v, e);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        #3;
        if (q.size() > 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expectations left, expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
